// File: rtl/attn_qk_score_seq.sv
`default_nettype none
// ============================================================================
// Module  : attn_qk_score_seq
// Purpose : Time-multiplexed attention score engine.
//           S[i][j] = sat((Q_i . K_j) >>> (FRAC_BITS+SCALE_SHIFT)), streamed
//           row-major over a valid/ready port. An optional causal mask is
//           supported, and a small set of shared multipliers computes every
//           dot product.
// Revision: 1.0  initial release
// ============================================================================
module attn_qk_score_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int TOKEN_DIM   = 4,
  parameter int TOKEN_NUM   = 8,
  parameter int MAC_LANES   = 2,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]   Q,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]   K,
  input  logic                                        causal,
  output logic                                        s_valid,
  input  logic                                        s_ready,
  output logic [DATA_WIDTH-1:0]                       s_data,
  output logic [$clog2(TOKEN_NUM)-1:0]                s_row,
  output logic [$clog2(TOKEN_NUM)-1:0]                s_col,
  output logic                                        s_last,
  output logic                                        done
);

  localparam int C_NB    = (TOKEN_DIM + MAC_LANES - 1) / MAC_LANES;
  localparam int C_GRP_W = (C_NB > 1) ? $clog2(C_NB) : 1;
  localparam int C_IDX_W = $clog2(TOKEN_NUM);
  localparam int C_ACC_W = 2*DATA_WIDTH + $clog2(TOKEN_DIM) + 1;
  localparam int C_PRD_W = 2*DATA_WIDTH;
  localparam int C_SHIFT = FRAC_BITS + SCALE_SHIFT;
  localparam int C_MAT_W = DATA_WIDTH*TOKEN_DIM*TOKEN_NUM;

  localparam logic [DATA_WIDTH-1:0] C_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] C_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [C_IDX_W-1:0]    C_END  = C_IDX_W'(TOKEN_NUM-1);
  localparam logic [C_GRP_W-1:0]    C_GEND = C_GRP_W'(C_NB-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                      r_state;
  logic [C_MAT_W-1:0]          r_q;
  logic [C_MAT_W-1:0]          r_k;
  logic                        r_causal;
  logic [C_GRP_W-1:0]          r_grp;
  logic signed [C_ACC_W-1:0]   r_acc;

  logic signed [C_PRD_W-1:0]   w_prod [MAC_LANES];
  logic signed [C_ACC_W-1:0]   w_sum;
  logic signed [C_ACC_W-1:0]   w_acc_next;
  logic signed [C_ACC_W-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]       w_sat;
  logic                        w_last;
  logic [C_IDX_W-1:0]          w_nrow;
  logic [C_IDX_W-1:0]          w_ncol;
  logic                        w_nmask;
  logic                        w_nlast;

  assign in_ready = (r_state == S_IDLE);

  // One multiplier per lane: product of the current lane group's element pair
  for (genvar l = 0; l < MAC_LANES; l++) begin : g_lane
    always_comb begin
      int d;
      d         = int'(r_grp) * MAC_LANES + l;
      w_prod[l] = '0;
      if (d < TOKEN_DIM) begin
        w_prod[l] = $signed(r_q[(int'(s_row)*TOKEN_DIM + d)*DATA_WIDTH +: DATA_WIDTH])
                  * $signed(r_k[(int'(s_col)*TOKEN_DIM + d)*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  // Reduce the lane products, scale with floor rounding, then saturate
  always_comb begin
    w_sum = '0;
    for (int l = 0; l < MAC_LANES; l++) begin
      w_sum = w_sum + {{(C_ACC_W-C_PRD_W){w_prod[l][C_PRD_W-1]}}, w_prod[l]};
    end
    w_acc_next = r_acc + w_sum;
    w_shifted  = w_acc_next >>> C_SHIFT;
    // In range only when every bit above the output sign bit matches it
    if (&w_shifted[C_ACC_W-1:DATA_WIDTH-1] || ~|w_shifted[C_ACC_W-1:DATA_WIDTH-1]) begin
      w_sat = w_shifted[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_shifted[C_ACC_W-1] ? C_MIN : C_MAX;
    end
  end

  // Row-major successor of the current element and whether it is masked
  always_comb begin
    w_last = (s_row == C_END) && (s_col == C_END);
    if (s_col == C_END) begin
      w_ncol = '0;
      w_nrow = s_row + C_IDX_W'(1);
    end else begin
      w_ncol = s_col + C_IDX_W'(1);
      w_nrow = s_row;
    end
    w_nmask = r_causal && (w_ncol > w_nrow);
    w_nlast = (w_nrow == C_END) && (w_ncol == C_END);
  end

  // Control FSM with registered score port; s_row/s_col double as the element pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_k      <= '0;
      r_causal <= 1'b0;
      r_grp    <= '0;
      r_acc    <= '0;
      s_valid  <= 1'b0;
      s_data   <= '0;
      s_row    <= '0;
      s_col    <= '0;
      s_last   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q      <= Q;
            r_k      <= K;
            r_causal <= causal;
            s_row    <= '0;
            s_col    <= '0;
            r_grp    <= '0;
            r_acc    <= '0;
            // Element (0,0) sits on the diagonal and is never masked
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_grp == C_GEND) begin
            s_data  <= w_sat;
            s_last  <= w_last;
            s_valid <= 1'b1;
            r_state <= S_OUT;
          end else begin
            r_acc <= w_acc_next;
            r_grp <= r_grp + C_GRP_W'(1);
          end
        end
        S_OUT: begin
          if (s_ready) begin
            if (w_last) begin
              s_valid <= 1'b0;
              done    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              s_row <= w_nrow;
              s_col <= w_ncol;
              if (w_nmask) begin
                // Masked scores skip the MAC phase: no bubble on the stream
                s_data <= C_MIN;
                s_last <= w_nlast;
              end else begin
                s_valid <= 1'b0;
                r_acc   <= '0;
                r_grp   <= '0;
                r_state <= S_MAC;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attn_qk_score_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_attn_qk_score_seq
// Purpose : Self-checking bench for attn_qk_score_seq. Expected scores are
//           computed by a reference model when a matrix is loaded, queued,
//           and compared as the DUT hands them over.
// Revision: 1.0  initial release
// ============================================================================
module tb_attn_qk_score_seq;

  localparam int DW = 16;
  localparam int TD = 4;
  localparam int TN = 8;
  localparam int W  = DW*TD*TN;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  q_in;
  logic [W-1:0]  k_in;
  logic          causal;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [2:0]    s_row;
  logic [2:0]    s_col;
  logic          s_last;
  logic          done;

  typedef struct packed {
    logic [2:0]  row;
    logic [2:0]  col;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;
  int   cyc    = 0;

  attn_qk_score_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Q        (q_in),
    .K        (k_in),
    .causal   (causal),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_row    (s_row),
    .s_col    (s_col),
    .s_last   (s_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor-shifted dot product with saturation, or mask value
  function automatic logic [15:0] model(input logic [W-1:0] q, input logic [W-1:0] k,
                                        input bit c, input int r, input int cc);
    longint acc;
    logic [15:0] res;
    if (c && cc > r) return 16'h8000;
    acc = 0;
    for (int d = 0; d < TD; d++) begin
      acc += longint'($signed(q[(r*TD+d)*DW +: DW])) * longint'($signed(k[(cc*TD+d)*DW +: DW]));
    end
    acc = acc >>> 9;
    if (acc > 32767) return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    res = acc[15:0];
    return res;
  endfunction

  task automatic fill_const(input logic [15:0] qv, input logic [15:0] kv);
    for (int i = 0; i < TD*TN; i++) begin
      q_in[i*DW +: DW] = qv;
      k_in[i*DW +: DW] = kv;
    end
  endtask

  // span 0: full 16-bit random; otherwise uniform in [-span, span]
  task automatic fill_rand(input int span);
    for (int i = 0; i < TD*TN; i++) begin
      if (span == 0) begin
        q_in[i*DW +: DW] = 16'($urandom);
        k_in[i*DW +: DW] = 16'($urandom);
      end else begin
        q_in[i*DW +: DW] = 16'(int'($urandom_range(0, 2*span)) - span);
        k_in[i*DW +: DW] = 16'(int'($urandom_range(0, 2*span)) - span);
      end
    end
  endtask

  task automatic load(input bit c, output int accept);
    exp_t e;
    @(posedge clk); #1;
    for (int r = 0; r < TN; r++) begin
      for (int cc = 0; cc < TN; cc++) begin
        e.row  = 3'(r);
        e.col  = 3'(cc);
        e.data = model(q_in, k_in, c, r, cc);
        e.last = (r == TN-1) && (cc == TN-1);
        sb.push_back(e);
      end
    end
    causal   = c;
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    accept = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int accept, input int exp_cycles);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("in_ready_at_done", in_ready, 1);
    check("s_valid_at_done", s_valid, 0);
    if (seen && exp_cycles > 0) check("latency", cyc - accept, exp_cycles);
    check("sb_drained", sb.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  // Scoreboard consumer: every handshake pops one expected score
  always @(negedge clk) begin
    if (rst === 1'b0 && s_valid === 1'b1 && s_ready === 1'b1) begin
      hs_cnt++;
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check($sformatf("score(%0d,%0d){row,col,data,last}", mon_e.row, mon_e.col),
              {s_row, s_col, s_data, s_last}, mon_e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   acc;
    bit   found;
    logic [15:0] held;

    // Reset: in_valid high must not be captured
    rst = 1'b1; in_valid = 1'b1; causal = 1'b0; s_ready = 1'b1;
    fill_const(16'h0100, 16'h0100);
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_s_valid", s_valid, 0);
    check("rst_done", done, 0);
    check("rst_s_data", s_data, 0);
    check("rst_s_last", s_last, 0);
    check("rst_pos", {s_row, s_col}, 0);
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle_valid", s_valid, 0);
    check("post_rst_idle_ready", in_ready, 1);

    // 1: 1.0 x 1.0 -> 0x0200 everywhere, 192 cycles
    fill_const(16'h0100, 16'h0100);
    load(1'b0, acc); wait_done(acc, 192);

    // 2: negative values and floor rounding
    fill_const(16'hFF00, 16'h0100);
    load(1'b0, acc); wait_done(acc, 192);
    fill_const(16'h0001, 16'h0001);
    load(1'b0, acc); wait_done(acc, 192);
    fill_const(16'hFFFF, 16'h0001);
    load(1'b0, acc); wait_done(acc, 192);

    // 3: saturation both ways
    fill_const(16'h7FFF, 16'h7FFF);
    load(1'b0, acc); wait_done(acc, 192);
    fill_const(16'h7FFF, 16'h8000);
    load(1'b0, acc); wait_done(acc, 192);

    // 4: causal mask, no bubble on masked elements
    fill_const(16'h0100, 16'h0100);
    load(1'b1, acc); wait_done(acc, 136);
    fill_rand(600);
    load(1'b1, acc); wait_done(acc, 136);
    fill_rand(0);
    load(1'b0, acc); wait_done(acc, 192);

    // 5: back-pressure on (0,3); busy loads ignored
    fill_rand(300);
    load(1'b0, acc);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (s_row == 3'd0 && s_col == 3'd3 && s_valid === 1'b0) begin
        s_ready = 1'b0;
        found   = 1'b1;
        break;
      end
    end
    check("stall_reached", found, 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_valid === 1'b1) break;
    end
    check("stall_valid", s_valid, 1);
    held = s_data;
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      q_in     = ~q_in;
      @(negedge clk);
      check("hold_valid", s_valid, 1);
      check("hold_data", s_data, held);
      check("hold_pos", {s_row, s_col}, {3'd0, 3'd3});
      check("busy_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    s_ready  = 1'b1;
    in_valid = 1'b0;
    wait_done(acc, 0);

    // 6: reset after the 10th handshake aborts, then a clean restart
    hs_cnt = 0;
    fill_rand(2000);
    load(1'b0, acc);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (hs_cnt == 10) break;
    end
    check("abort_point", hs_cnt, 10);
    rst = 1'b1;
    #1;
    check("abort_s_valid", s_valid, 0);
    check("abort_done", done, 0);
    check("abort_in_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check("abort_no_done", done, 0);
    fill_rand(400);
    load(1'b0, acc); wait_done(acc, 192);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
